// File: rtl/alu_pkg.sv
// Shared operation encodings for the pipelined integer ALU.
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 bit selecting SUB over ADD and SRA over SRL.
  localparam int F7_ALT_BIT = 5;

endpackage

// File: rtl/alu_pipe_shifter.sv
// Logarithmic barrel shifter; left shifts reuse the right-shift network by bit reversal.
module barrel_shifter_n #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               left,
  input  logic               arith,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0] stage [SHAMT_W+1];
  logic [WIDTH-1:0] revIn;
  logic [WIDTH-1:0] revOut;
  logic             fill;

  always_comb begin
    revIn = '0;
    for (int i = 0; i < WIDTH; i++) revIn[i] = data[WIDTH-1-i];
  end

  assign stage[0] = left ? revIn : data;
  assign fill     = arith && !left && data[WIDTH-1];

  for (genvar k = 0; k < SHAMT_W; k++) begin : gStage
    localparam int S = 1 << k;
    assign stage[k+1] = shamt[k] ? {{S{fill}}, stage[k][WIDTH-1:S]} : stage[k];
  end

  always_comb begin
    revOut = '0;
    for (int i = 0; i < WIDTH; i++) revOut[i] = stage[SHAMT_W][WIDTH-1-i];
  end

  assign result = left ? revOut : stage[SHAMT_W];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshakes and backpressure.
// S1 captures operands and the effective shift amount; S2 evaluates and registers the result.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SHAMT_W   = $clog2(WIDTH),
  parameter int SHIFT_SAT = 1
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iDataA,
  input  logic [WIDTH-1:0] iDataB,
  input  logic [2:0]       iFunct3,
  input  logic [6:0]       iFunct7,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData,
  output logic             oZero
);

  // Oversized shift amounts either clamp to WIDTH-1 or wrap modulo WIDTH.
  function automatic logic [SHAMT_W-1:0] satShamt(input logic [WIDTH-1:0] b);
    if ((SHIFT_SAT != 0) && ((b >> SHAMT_W) != '0))
      return SHAMT_W'(WIDTH - 1);
    return b[SHAMT_W-1:0];
  endfunction

  logic               vld_p1;
  logic               vld_p2;
  logic [WIDTH-1:0]   dataA_p1;
  logic [WIDTH-1:0]   dataB_p1;
  logic [2:0]         funct3_p1;
  logic               alt_p1;
  logic [SHAMT_W-1:0] shamt_p1;
  logic               s1Load;
  logic               s2Load;
  logic               unusedF7;

  assign unusedF7 = ^{iFunct7[6], iFunct7[4:0]};

  assign s2Load = vld_p1 && (!vld_p2 || iReady);
  assign oReady = !vld_p1 || s2Load;
  assign s1Load = iValid && oReady;

  // ---- S1: operand capture ----
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      vld_p1    <= 1'b0;
      dataA_p1  <= '0;
      dataB_p1  <= '0;
      funct3_p1 <= '0;
      alt_p1    <= 1'b0;
      shamt_p1  <= '0;
    end else begin
      if (s1Load)      vld_p1 <= 1'b1;
      else if (s2Load) vld_p1 <= 1'b0;
      if (s1Load) begin
        dataA_p1  <= iDataA;
        dataB_p1  <= iDataB;
        funct3_p1 <= iFunct3;
        alt_p1    <= iFunct7[F7_ALT_BIT];
        shamt_p1  <= satShamt(iDataB);
      end
    end
  end

  // ---- S2: evaluate and register result ----
  logic signed [WIDTH-1:0] sgnA_p1;
  logic signed [WIDTH-1:0] sgnB_p1;
  logic [WIDTH-1:0]        sum;
  logic [WIDTH-1:0]        shiftOut;
  logic [WIDTH-1:0]        result;
  logic                    shiftLeft;

  assign sgnA_p1   = dataA_p1;
  assign sgnB_p1   = dataB_p1;
  assign sum       = alt_p1 ? dataA_p1 - dataB_p1 : dataA_p1 + dataB_p1;
  assign shiftLeft = (funct3_p1 == F3_SLL);

  barrel_shifter_n #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) uShift (
    .data  (dataA_p1),
    .shamt (shamt_p1),
    .left  (shiftLeft),
    .arith (alt_p1),
    .result(shiftOut)
  );

  always_comb begin
    result = '0;
    case (funct3_p1)
      F3_ADD:        result = sum;
      F3_SLL, F3_SR: result = shiftOut;
      F3_SLT:        result = WIDTH'(sgnA_p1 < sgnB_p1);
      F3_SLTU:       result = WIDTH'(dataA_p1 < dataB_p1);
      F3_XOR:        result = dataA_p1 ^ dataB_p1;
      F3_OR:         result = dataA_p1 | dataB_p1;
      F3_AND:        result = dataA_p1 & dataB_p1;
      default:       result = '0;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      vld_p2 <= 1'b0;
      oData  <= '0;
      oZero  <= 1'b1;
    end else begin
      if (s2Load)      vld_p2 <= 1'b1;
      else if (iReady) vld_p2 <= 1'b0;
      if (s2Load) begin
        oData <= result;
        oZero <= ~|result;
      end
    end
  end

  assign oValid = vld_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors, parameter variants, streaming, stalls and mid-flight reset.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic        iValid, oReady, oValid, iReady, oZero;
  logic [31:0] iDataA, iDataB, oData;
  logic [2:0]  iFunct3;
  logic [6:0]  iFunct7;

  logic        s0Valid, s0Rdy, s0OValid, s0Zero;
  logic [31:0] s0A, s0B, s0Data;
  logic [2:0]  s0F3;
  logic [6:0]  s0F7;

  logic        w8Valid, w8Rdy, w8OValid, w8Zero;
  logic [7:0]  w8A, w8B, w8Data;
  logic [2:0]  w8F3;
  logic [6:0]  w8F7;

  alu_pipe #(.WIDTH(32), .SHIFT_SAT(1)) dut (
    .iClk(clk), .iRstN(rstN), .iValid(iValid), .oReady(oReady),
    .iDataA(iDataA), .iDataB(iDataB), .iFunct3(iFunct3), .iFunct7(iFunct7),
    .oValid(oValid), .iReady(iReady), .oData(oData), .oZero(oZero)
  );

  alu_pipe #(.WIDTH(32), .SHIFT_SAT(0)) dutSat0 (
    .iClk(clk), .iRstN(rstN), .iValid(s0Valid), .oReady(s0Rdy),
    .iDataA(s0A), .iDataB(s0B), .iFunct3(s0F3), .iFunct7(s0F7),
    .oValid(s0OValid), .iReady(1'b1), .oData(s0Data), .oZero(s0Zero)
  );

  alu_pipe #(.WIDTH(8), .SHIFT_SAT(1)) dutW8 (
    .iClk(clk), .iRstN(rstN), .iValid(w8Valid), .oReady(w8Rdy),
    .iDataA(w8A), .iDataB(w8B), .iFunct3(w8F3), .iFunct7(w8F7),
    .oValid(w8OValid), .iReady(1'b1), .oData(w8Data), .oZero(w8Zero)
  );

  int nChecks = 0;
  int nPass   = 0;
  longint unsigned expQ[$];

  // Reference: the architectural result computed directly from the operation rules.
  function automatic longint unsigned model(input longint unsigned a, input longint unsigned b,
                                            input logic [2:0] f3, input logic alt,
                                            input int w, input bit sat);
    longint unsigned mask, r, ua, ub;
    longint sa, sb;
    int sh;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 1);
    ua = a & mask;
    ub = b & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (w < 64 && ((ua >> (w - 1)) & 1) != 0) sa = longint'(ua | ~mask);
    if (w < 64 && ((ub >> (w - 1)) & 1) != 0) sb = longint'(ub | ~mask);
    if (sat && (ub >> $clog2(w)) != 0) sh = w - 1;
    else sh = int'(ub % longint'(w));
    case (f3)
      3'd0:    r = alt ? ua - ub : ua + ub;
      3'd1:    r = ua << sh;
      3'd2:    r = (sa < sb) ? 1 : 0;
      3'd3:    r = (ua < ub) ? 1 : 0;
      3'd4:    r = ua ^ ub;
      3'd5:    r = alt ? longint'(sa >>> sh) : ua >> sh;
      3'd6:    r = ua | ub;
      default: r = ua & ub;
    endcase
    return r & mask;
  endfunction

  // One clock of the main instance: drive at negedge, sample and record the handshakes.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input logic [6:0] f7, input logic rdy,
                       output logic acc, output logic ov, output logic [31:0] d,
                       output logic z, output logic ordy);
    @(negedge clk);
    iValid = v; iDataA = a; iDataB = b; iFunct3 = f3; iFunct7 = f7; iReady = rdy;
    #1;
    ordy = oReady;
    acc  = iValid && oReady;
    if (acc) expQ.push_back(model(a, b, f3, f7[5], 32, 1'b1));
    ov = oValid; d = oData; z = oZero;
    @(posedge clk);
  endtask

  task automatic randOp(output logic [31:0] a, output logic [31:0] b,
                        output logic [2:0] f3, output logic [6:0] f7);
    a = $urandom();
    if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       b = 32'($urandom_range(0, 40));
      1:       b = a;
      default: b = $urandom();
    endcase
    f3 = 3'($urandom_range(0, 7));
    f7 = 7'($urandom());
  endtask

  task automatic test_reset();
    nChecks++; if (oValid !== 1'b0) $display("FAIL reset_oValid: got %b want 0", oValid); else nPass++;
    nChecks++; if (oData !== 32'h0) $display("FAIL reset_oData: got %h want 0", oData); else nPass++;
    nChecks++; if (oZero !== 1'b1) $display("FAIL reset_oZero: got %b want 1", oZero); else nPass++;
    nChecks++; if (oReady !== 1'b1) $display("FAIL reset_oReady: got %b want 1", oReady); else nPass++;
    rstN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nChecks++; if (oValid !== 1'b0) $display("FAIL post_reset_oValid: got %b want 0", oValid); else nPass++;
  endtask

  task automatic test_directed();
    logic [31:0] ta [9] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'd1, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0};
    logic [31:0] tb [9] = '{32'd1, 32'd5, 32'h20, 32'h100, 32'd1,
                            32'd1, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00};
    logic [2:0]  tf3 [9] = '{3'd0, 3'd0, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    logic [6:0]  tf7 [9] = '{7'h00, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    logic [31:0] te [9] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1,
                            32'h0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'hF000F000};
    logic acc, ov, z, ordy;
    logic [31:0] d;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, ta[i], tb[i], tf3[i], tf7[i], 1'b1, acc, ov, d, z, ordy);
      nChecks++; if (acc !== 1'b1) $display("FAIL dir%0d_accept: got %b want 1", i, acc); else nPass++;
      cycle(1'b0, 32'h0, 32'h0, 3'd0, 7'h0, 1'b1, acc, ov, d, z, ordy);
      nChecks++; if (ov !== 1'b0) $display("FAIL dir%0d_early_valid: got %b want 0", i, ov); else nPass++;
      cycle(1'b0, 32'h0, 32'h0, 3'd0, 7'h0, 1'b1, acc, ov, d, z, ordy);
      nChecks++; if (ov !== 1'b1) $display("FAIL dir%0d_valid: got %b want 1", i, ov); else nPass++;
      nChecks++; if (d !== te[i]) $display("FAIL dir%0d_data: got %h want %h", i, d, te[i]); else nPass++;
      nChecks++; if (z !== (te[i] == 32'h0)) $display("FAIL dir%0d_zero: got %b want %b", i, z, te[i] == 32'h0); else nPass++;
    end
    expQ.delete();
  endtask

  task automatic test_variants();
    logic [31:0] sa [2] = '{32'h80000000, 32'd1};
    logic [31:0] sb [2] = '{32'h20, 32'h100};
    logic [2:0]  sf3 [2] = '{3'd5, 3'd1};
    logic [6:0]  sf7 [2] = '{7'h20, 7'h00};
    logic [31:0] se [2] = '{32'h80000000, 32'd1};
    logic [7:0]  wa [2] = '{8'h90, 8'h01};
    logic [7:0]  wb [2] = '{8'h03, 8'h10};
    logic [7:0]  we [2] = '{8'hF2, 8'h80};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s0Valid = 1'b1; s0A = sa[i]; s0B = sb[i]; s0F3 = sf3[i]; s0F7 = sf7[i];
      w8Valid = 1'b1; w8A = wa[i]; w8B = wb[i]; w8F3 = sf3[i]; w8F7 = sf7[i];
      @(negedge clk);
      s0Valid = 1'b0; w8Valid = 1'b0;
      @(negedge clk);
      nChecks++; if (s0OValid !== 1'b1) $display("FAIL sat0_%0d_valid: got %b want 1", i, s0OValid); else nPass++;
      nChecks++; if (s0Data !== se[i]) $display("FAIL sat0_%0d_data: got %h want %h", i, s0Data, se[i]); else nPass++;
      nChecks++; if (w8OValid !== 1'b1) $display("FAIL w8_%0d_valid: got %b want 1", i, w8OValid); else nPass++;
      nChecks++; if (w8Data !== we[i]) $display("FAIL w8_%0d_data: got %h want %h", i, w8Data, we[i]); else nPass++;
      nChecks++; if (w8Zero !== 1'b0) $display("FAIL w8_%0d_zero: got %b want 0", i, w8Zero); else nPass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic acc, ov, z, ordy;
    longint unsigned e;
    for (int k = 0; k < 12; k++) begin
      randOp(a, b, f3, f7);
      cycle(k < 8, a, b, f3, f7, 1'b1, acc, ov, d, z, ordy);
      nChecks++;
      if (ov !== (k >= 2 && k <= 9)) $display("FAIL stream_valid_c%0d: got %b want %b", k, ov, (k >= 2 && k <= 9));
      else nPass++;
      if (ov === 1'b1) begin
        nChecks++;
        if (expQ.size() == 0) $display("FAIL stream_extra_c%0d: got result %h want none", k, d);
        else begin
          e = expQ.pop_front();
          if (d !== 32'(e) || z !== (e == 0)) $display("FAIL stream_data_c%0d: got %h/%b want %h/%b", k, d, z, 32'(e), e == 0);
          else nPass++;
        end
      end
    end
    nChecks++; if (expQ.size() != 0) $display("FAIL stream_left: got %0d pending want 0", expQ.size()); else nPass++;
    expQ.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, d, held;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic acc, ov, z, ordy;
    int accepts = 0;
    int outs = 0;
    longint unsigned e;
    held = '0;
    randOp(a, b, f3, f7);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, a, b, f3, f7, 1'b0, acc, ov, d, z, ordy);
      if (acc) begin accepts++; randOp(a, b, f3, f7); end
      if (k == 2) held = d;
      if (k >= 2) begin
        nChecks++; if (ov !== 1'b1) $display("FAIL stall_valid_c%0d: got %b want 1", k, ov); else nPass++;
        nChecks++; if (ordy !== 1'b0) $display("FAIL stall_ready_c%0d: got %b want 0", k, ordy); else nPass++;
        nChecks++; if (d !== held) $display("FAIL stall_hold_c%0d: got %h want %h", k, d, held); else nPass++;
      end
    end
    nChecks++; if (accepts != 2) $display("FAIL stall_accepts: got %0d want 2", accepts); else nPass++;
    for (int k = 0; k < 10 && expQ.size() > 0; k++) begin
      cycle(1'b0, 32'h0, 32'h0, 3'd0, 7'h0, 1'b1, acc, ov, d, z, ordy);
      if (ov === 1'b1) begin
        outs++;
        e = expQ.pop_front();
        nChecks++;
        if (d !== 32'(e)) $display("FAIL drain_data_%0d: got %h want %h", outs, d, 32'(e)); else nPass++;
      end
    end
    nChecks++; if (outs != 2) $display("FAIL drain_count: got %0d want 2", outs); else nPass++;
    cycle(1'b0, 32'h0, 32'h0, 3'd0, 7'h0, 1'b1, acc, ov, d, z, ordy);
    nChecks++; if (ov !== 1'b0) $display("FAIL drain_dup: got %b want 0", ov); else nPass++;
    expQ.delete();
  endtask

  task automatic test_random();
    logic [31:0] a, b, d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic acc, ov, z, ordy, v, r;
    longint unsigned e;
    randOp(a, b, f3, f7);
    for (int k = 0; k < 310; k++) begin
      v = (k < 300) && ($urandom_range(0, 9) < 7);
      r = (k >= 300) || ($urandom_range(0, 9) < 7);
      cycle(v, a, b, f3, f7, r, acc, ov, d, z, ordy);
      if (acc) randOp(a, b, f3, f7);
      if (ov === 1'b1 && r) begin
        nChecks++;
        if (expQ.size() == 0) $display("FAIL rand_extra_c%0d: got result %h want none", k, d);
        else begin
          e = expQ.pop_front();
          if (d !== 32'(e) || z !== (e == 0)) $display("FAIL rand_data_c%0d: got %h/%b want %h/%b", k, d, z, 32'(e), e == 0);
          else nPass++;
        end
      end
    end
    nChecks++; if (expQ.size() != 0) $display("FAIL rand_left: got %0d pending want 0", expQ.size()); else nPass++;
    expQ.delete();
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    logic acc, ov, z, ordy;
    cycle(1'b1, 32'h12345678, 32'd1, 3'd0, 7'h0, 1'b0, acc, ov, d, z, ordy);
    cycle(1'b1, 32'h00000F00, 32'h00000FF0, 3'd6, 7'h0, 1'b0, acc, ov, d, z, ordy);
    @(negedge clk);
    iValid = 1'b0;
    #1;
    nChecks++; if (oValid !== 1'b1) $display("FAIL inflight_valid: got %b want 1", oValid); else nPass++;
    #1 rstN = 1'b0;
    #1;
    nChecks++; if (oValid !== 1'b0) $display("FAIL arst_oValid: got %b want 0", oValid); else nPass++;
    nChecks++; if (oData !== 32'h0) $display("FAIL arst_oData: got %h want 0", oData); else nPass++;
    nChecks++; if (oZero !== 1'b1) $display("FAIL arst_oZero: got %b want 1", oZero); else nPass++;
    nChecks++; if (oReady !== 1'b1) $display("FAIL arst_oReady: got %b want 1", oReady); else nPass++;
    @(negedge clk);
    rstN = 1'b1;
    expQ.delete();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 32'h0, 32'h0, 3'd0, 7'h0, 1'b1, acc, ov, d, z, ordy);
      nChecks++; if (ov !== 1'b0) $display("FAIL post_arst_valid_c%0d: got %b want 0", k, ov); else nPass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    iValid = 1'b0; iDataA = '0; iDataB = '0; iFunct3 = '0; iFunct7 = '0; iReady = 1'b1;
    s0Valid = 1'b0; s0A = '0; s0B = '0; s0F3 = '0; s0F7 = '0;
    w8Valid = 1'b0; w8A = '0; w8B = '0; w8F3 = '0; w8F7 = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_directed();
    test_variants();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
